// File: rtl/weight_update_module.sv
// weight_update_module: parameter store and serial SGD update engine.
// Holds 74 signed Q(FRAC) parameters (w3, w2, b3, b2). A start pulse captures
// the delta buses and the learning rate. One parameter per cycle is then
// updated as w <- sat(w - (lr*dw >>> FRAC)).
module weight_update_module #(
    parameter int FRAC    = 11,
    parameter int N_PARAM = 74
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [15:0]  lr,
    input  logic [319:0] deltaw3,
    input  logic [719:0] deltaw2,
    input  logic [63:0]  deltab3,
    input  logic [79:0]  deltab2,
    input  logic         load_en,
    input  logic [6:0]   load_addr,
    input  logic [15:0]  load_data,
    output logic [319:0] w3,
    output logic [719:0] w2,
    output logic [63:0]  b3,
    output logic [79:0]  b2,
    output logic         busy,
    output logic         done,
    output logic [15:0]  update_count
);

    localparam int W3_BASE = 0;
    localparam int W2_BASE = 20;
    localparam int B3_BASE = 65;
    localparam int B2_BASE = 69;
    localparam logic [6:0] LAST_IDX  = 7'(N_PARAM - 1);
    localparam logic [6:0] N_PARAM_7 = 7'(N_PARAM);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_UPDATE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [15:0]  param_q [N_PARAM];
    logic [15:0]  param_d [N_PARAM];
    logic [15:0]  dcap_q  [N_PARAM];
    logic [15:0]  dcap_d  [N_PARAM];
    logic [15:0]  delta_in_s [N_PARAM];
    logic [15:0]  lr_q, lr_d;
    logic [6:0]   idx_q, idx_d;
    logic [15:0]  count_q, count_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic         capture_s;
    logic         upd_en_s;
    logic         load_ok_s;
    logic [15:0]  cur_s;
    logic signed [31:0] prod_s;
    logic signed [31:0] shift_s;
    logic signed [32:0] diff_s;
    logic [15:0]  upd_val_s;

    // Clamp a 33-bit signed difference into the signed 16-bit range.
    function automatic logic [15:0] sat16(input logic signed [32:0] v);
        logic [15:0] r;
        if (v > 33'sd32767) begin
            r = 16'h7FFF;
        end else if (v < -33'sd32768) begin
            r = 16'h8000;
        end else begin
            r = v[15:0];
        end
        return r;
    endfunction

    // Unpack the flat delta buses into the shared flat parameter index map.
    always_comb begin
        for (int k = 0; k < N_PARAM; k++) delta_in_s[k] = 16'd0;
        for (int k = 0; k < 20; k++) delta_in_s[W3_BASE + k] = deltaw3[16*k +: 16];
        for (int k = 0; k < 45; k++) delta_in_s[W2_BASE + k] = deltaw2[16*k +: 16];
        for (int k = 0; k < 4;  k++) delta_in_s[B3_BASE + k] = deltab3[16*k +: 16];
        for (int k = 0; k < 5;  k++) delta_in_s[B2_BASE + k] = deltab2[16*k +: 16];
    end

    // Pack stored parameters back onto the flat output buses.
    always_comb begin
        w3 = 320'd0;
        w2 = 720'd0;
        b3 = 64'd0;
        b2 = 80'd0;
        for (int k = 0; k < 20; k++) w3[16*k +: 16] = param_q[W3_BASE + k];
        for (int k = 0; k < 45; k++) w2[16*k +: 16] = param_q[W2_BASE + k];
        for (int k = 0; k < 4;  k++) b3[16*k +: 16] = param_q[B3_BASE + k];
        for (int k = 0; k < 5;  k++) b2[16*k +: 16] = param_q[B2_BASE + k];
    end

    // FSM next-state: IDLE/DONE accept start, UPDATE runs until the last index.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_UPDATE;
                else       state_d = S_IDLE;
            end
            S_UPDATE: begin
                if (idx_q == LAST_IDX) state_d = S_DONE;
                else                   state_d = S_UPDATE;
            end
            S_DONE: begin
                if (start) state_d = S_UPDATE;
                else       state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: control strobes and next values of the registered flags.
    always_comb begin
        capture_s = 1'b0;
        upd_en_s  = 1'b0;
        load_ok_s = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                capture_s = start;
                load_ok_s = load_en & ~start & (load_addr < N_PARAM_7);
            end
            S_UPDATE: begin
                upd_en_s = 1'b1;
            end
            default: begin
                capture_s = 1'b0;
            end
        endcase
        busy_d = (state_d == S_UPDATE);
        done_d = (state_d == S_DONE);
    end

    // Update arithmetic for the parameter currently addressed by idx.
    always_comb begin
        cur_s     = param_q[idx_q];
        prod_s    = $signed(lr_q) * $signed(dcap_q[idx_q]);
        shift_s   = prod_s >>> FRAC;
        diff_s    = $signed({{17{cur_s[15]}}, cur_s}) - $signed({shift_s[31], shift_s});
        upd_val_s = sat16(diff_s);
    end

    // Next values for storage, capture registers, index and pass counter.
    always_comb begin
        param_d = param_q;
        dcap_d  = dcap_q;
        lr_d    = lr_q;
        idx_d   = idx_q;
        count_d = count_q;
        if (capture_s) begin
            dcap_d = delta_in_s;
            lr_d   = lr;
            idx_d  = 7'd0;
        end else if (upd_en_s) begin
            param_d[idx_q] = upd_val_s;
            if (idx_q == LAST_IDX) begin
                idx_d   = 7'd0;
                count_d = count_q + 16'd1;
            end else begin
                idx_d = idx_q + 7'd1;
            end
        end else if (load_ok_s) begin
            param_d[load_addr] = load_data;
        end else begin
            idx_d = idx_q;
        end
    end

    // State register with synchronous reset; reset aborts any pass in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_PARAM; k++) begin
                param_q[k] <= 16'd0;
                dcap_q[k]  <= 16'd0;
            end
            state_q <= S_IDLE;
            lr_q    <= 16'd0;
            idx_q   <= 7'd0;
            count_q <= 16'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            param_q <= param_d;
            dcap_q  <= dcap_d;
            state_q <= state_d;
            lr_q    <= lr_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign update_count = count_q;

endmodule

// File: tb/tb_weight_update_module.sv
// Scoreboard bench for weight_update_module: each start pushes the expected
// parameter image, pass count and done cycle; a monitor checks on every done.
module tb_weight_update_module;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [15:0]  lr;
    logic [319:0] deltaw3;
    logic [719:0] deltaw2;
    logic [63:0]  deltab3;
    logic [79:0]  deltab2;
    logic         load_en;
    logic [6:0]   load_addr;
    logic [15:0]  load_data;
    logic [319:0] w3;
    logic [719:0] w2;
    logic [63:0]  b3;
    logic [79:0]  b2;
    logic         busy;
    logic         done;
    logic [15:0]  update_count;

    weight_update_module #(.FRAC(11), .N_PARAM(74)) dut (
        .clk(clk), .rst(rst), .start(start), .lr(lr),
        .deltaw3(deltaw3), .deltaw2(deltaw2), .deltab3(deltab3), .deltab2(deltab2),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .w3(w3), .w2(w2), .b3(b3), .b2(b2),
        .busy(busy), .done(done), .update_count(update_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [73:0][15:0] p;
        logic [15:0]       cnt;
        int                done_cyc;
    } exp_t;

    exp_t              sb [$];
    logic [73:0][15:0] em;
    logic [15:0]       ecnt;
    int                cyc = 0;
    int                vectors = 0;
    int                miscompares = 0;
    int                done_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] get_param(input int k);
        if (k < 20)      return w3[16*k +: 16];
        else if (k < 65) return w2[16*(k-20) +: 16];
        else if (k < 69) return b3[16*(k-65) +: 16];
        else             return b2[16*(k-69) +: 16];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic clr_deltas();
        deltaw3 = 320'd0;
        deltaw2 = 720'd0;
        deltab3 = 64'd0;
        deltab2 = 80'd0;
    endtask

    task automatic load(input logic [6:0] a, input logic [15:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    // Pulse start; optionally record the expected end-of-pass image, then
    // scramble the live inputs so only captured values can matter.
    task automatic run_start(input logic [15:0] l, input bit push);
        exp_t e;
        lr = l;
        start = 1'b1;
        if (push) begin
            e.p = em;
            e.cnt = ecnt;
            e.done_cyc = cyc + 75;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        deltaw3 = {320{1'b1}};
        deltaw2 = {720{1'b1}};
        deltab3 = {64{1'b1}};
        deltab2 = {80{1'b1}};
        lr = 16'h7FFF;
    endtask

    task automatic wait_done(input int maxc);
        int n = 0;
        while (done !== 1'b1 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", {31'd0, done}, 32'd1);
    endtask

    // Monitor: on each done pulse pop the oldest expectation and compare.
    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) begin
            exp_t e;
            done_seen++;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                for (int k = 0; k < 74; k++)
                    check($sformatf("param%0d", k), {16'd0, get_param(k)}, {16'd0, e.p[k]});
                check("update_count", {16'd0, update_count}, {16'd0, e.cnt});
                check("done_cycle", cyc, e.done_cyc);
                check("busy_in_done", {31'd0, busy}, 32'd0);
            end
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; lr = 16'd0; load_en = 1'b0;
        load_addr = 7'd0; load_data = 16'd0; clr_deltas();
        em = '0; ecnt = 16'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_count", {16'd0, update_count}, 32'd0);
        check("rst_params", {31'd0, (w3 == 320'd0 && w2 == 720'd0 && b3 == 64'd0 && b2 == 80'd0)}, 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Loads, including one out of range.
        load(7'd0, 16'd1024);  em[0] = 16'd1024;
        check("load_visible", {16'd0, get_param(0)}, 32'd1024);
        load(7'd30, 16'h1234); em[30] = 16'h1234;
        load(7'd70, 16'hFFFB); em[70] = 16'hFFFB;
        load(7'd100, 16'hABCD);

        // Basic update with mid-pass start re-pulse and an ignored load.
        clr_deltas();
        deltaw3[15:0] = 16'hF800;
        em[0] = 16'd1280; ecnt = 16'd1;
        run_start(16'd256, 1'b1);
        check("busy_rise", {31'd0, busy}, 32'd1);
        check("w3_0_before", {16'd0, get_param(0)}, 32'd1024);
        @(negedge clk);
        check("w3_0_after", {16'd0, get_param(0)}, 32'd1280);
        repeat (8) @(negedge clk);
        start = 1'b1; load_en = 1'b1; load_addr = 7'd5; load_data = 16'h5555;
        @(negedge clk);
        start = 1'b0; load_en = 1'b0;
        wait_done(100);
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 32'd0);

        // Saturation at both rails.
        load(7'd69, 16'h7FFF); em[69] = 16'h7FFF;
        load(7'd65, 16'h8000); em[65] = 16'h8000;
        clr_deltas();
        deltab2[15:0] = 16'h8000;
        deltab3[15:0] = 16'h7FFF;
        ecnt = 16'd2;
        run_start(16'h7FFF, 1'b1);
        wait_done(100);
        @(negedge clk);

        // Floor rounding: -1/2048 -> -1, +1/2048 -> 0.
        clr_deltas();
        deltaw2[15:0]  = 16'hFFFF;
        deltab3[31:16] = 16'h0001;
        em[20] = 16'd1; ecnt = 16'd3;
        run_start(16'd1, 1'b1);
        wait_done(100);
        @(negedge clk);

        // start together with load_en: load dropped.
        clr_deltas();
        load_en = 1'b1; load_addr = 7'd1; load_data = 16'h7777;
        ecnt = 16'd4;
        run_start(16'd0, 1'b1);
        load_en = 1'b0;
        wait_done(100);
        @(negedge clk);

        // Back-to-back passes on the last parameter (b2[4]).
        clr_deltas();
        deltab2[79:64] = 16'd100;
        em[73] = 16'hFF9C; ecnt = 16'd5;
        run_start(16'd2048, 1'b1);
        wait_done(100);
        clr_deltas();
        deltab2[79:64] = 16'd100;
        em[73] = 16'hFF38; ecnt = 16'd6;
        run_start(16'd2048, 1'b1);
        check("b2b_busy", {31'd0, busy}, 32'd1);
        wait_done(100);
        @(negedge clk);

        // Reset in the middle of a pass: no done, everything cleared.
        clr_deltas();
        deltaw3[15:0] = 16'd5;
        run_start(16'd2048, 1'b0);
        repeat (29) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_count", {16'd0, update_count}, 32'd0);
        check("abort_params", {31'd0, (w3 == 320'd0 && w2 == 720'd0 && b3 == 64'd0 && b2 == 80'd0)}, 32'd1);
        repeat (80) @(negedge clk);
        check("done_total", done_seen, 32'd6);
        check("sb_empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
